// File: rtl/seq_svm_classifier.sv
// Sequential one-vs-rest linear SVM: one feature per cycle into 10 class scores, then bias + arg-max.
// W_FLAT/B_FLAT default to zero and are meant to be overridden with the trained Pendigits set.
module seq_svm_classifier #(
    parameter int weightWidth  = 8,
    parameter int feature_bits = 5,
    parameter int N_features   = 17,
    parameter int biasWidth    = 8,
    parameter int inputWidth   = 4,
    parameter logic [10*N_features*weightWidth-1:0] W_FLAT = '0,
    parameter logic [10*biasWidth-1:0]              B_FLAT = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_features*inputWidth-1:0] in,
    output logic                             ready,
    output logic [3:0]                       w_class
);
    localparam int PW = weightWidth + inputWidth + 1;
    localparam int AW = weightWidth + inputWidth + feature_bits + 1;

    typedef enum logic [1:0] {S_ACC, S_FINAL, S_DONE} state_t;

    state_t                  state_q;
    logic [feature_bits-1:0] cnt_q;
    logic signed [AW-1:0]    acc_q   [10];
    logic signed [AW-1:0]    acc_d   [10];
    logic signed [AW-1:0]    score   [10];
    logic signed [weightWidth-1:0] w_sel [10];
    logic signed [PW-1:0]    prod    [10];
    logic [inputWidth-1:0]   x_sel;
    logic signed [AW-1:0]    best;
    logic [3:0]              best_idx;
    logic                    ready_q;
    logic [3:0]              w_class_q;

    // cnt-indexed mux over the constant weight table; folds to per-feature constants
    always_comb begin
        x_sel = '0;
        for (int c = 0; c < 10; c++) w_sel[c] = '0;
        for (int i = 0; i < N_features; i++) begin
            if (cnt_q == feature_bits'(i)) begin
                x_sel = in[i*inputWidth +: inputWidth];
                for (int c = 0; c < 10; c++)
                    w_sel[c] = W_FLAT[(c*N_features+i)*weightWidth +: weightWidth];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 10; c++) begin
            prod[c]  = PW'(w_sel[c]) * PW'(signed'({1'b0, x_sel}));
            acc_d[c] = acc_q[c] + AW'(prod[c]);
            score[c] = acc_q[c] + AW'(signed'(B_FLAT[c*biasWidth +: biasWidth]));
        end
    end

    // strict greater-than in class order: ties keep the lowest index
    always_comb begin
        best     = score[0];
        best_idx = '0;
        for (int c = 1; c < 10; c++) begin
            if (score[c] > best) begin
                best     = score[c];
                best_idx = 4'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_ACC;
            cnt_q     <= '0;
            acc_q     <= '{default: '0};
            ready_q   <= 1'b0;
            w_class_q <= '0;
        end else begin
            case (state_q)
                S_ACC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == feature_bits'(N_features - 1)) state_q <= S_FINAL;
                end
                S_FINAL: begin
                    w_class_q <= best_idx;
                    ready_q   <= 1'b1;
                    cnt_q     <= cnt_q + 1'b1;
                    state_q   <= S_DONE;
                end
                default: ;
            endcase
        end
    end

    assign ready   = ready_q;
    assign w_class = w_class_q;
endmodule

// File: tb/tb_seq_svm_classifier.sv
// Five classifier instances with hand-built coefficient sets; a scoreboard per instance
// checks latency, class, hold behaviour and asynchronous clearing.
module tb_seq_svm_classifier;
    localparam int ND = 5;

    function automatic logic [1359:0] mk_w(int mode);
        logic [1359:0] w;
        w = '0;
        for (int i = 0; i < 17; i++) begin
            if (mode == 1) w[(3*17+i)*8 +: 8] = 8'h01;
            if (mode == 2) begin
                w[(2*17+i)*8 +: 8] = 8'hFF;
                w[(5*17+i)*8 +: 8] = 8'h01;
            end
        end
        if (mode == 1) w[(6*17+16)*8 +: 8] = 8'h80;
        return w;
    endfunction

    function automatic logic [79:0] mk_b(int mode);
        logic [79:0] b;
        b = '0;
        for (int c = 0; c < 10; c++) begin
            if (mode == 0) b[c*8 +: 8] = 8'(c);
            if (mode == 4) b[c*8 +: 8] = 8'h80;
        end
        if (mode == 2) begin b[4*8 +: 8] = 8'd5; b[7*8 +: 8] = 8'd5; end
        if (mode == 3) b[6*8 +: 8] = 8'd127;
        if (mode == 4) begin b[2*8 +: 8] = 8'h00; b[5*8 +: 8] = 8'h9C; end
        return b;
    endfunction

    function automatic logic [67:0] fill(int v, int only16);
        logic [67:0] d;
        d = '0;
        for (int i = 0; i < 17; i++)
            if (!only16 || i == 16) d[i*4 +: 4] = 4'(v);
        return d;
    endfunction

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [ND-1:0][67:0]  din;
    logic [ND-1:0]        rdy;
    logic [ND-1:0][3:0]   cls;
    int                   cyc;
    int                   npass = 0;
    int                   ntot = 0;
    int                   exp_q [ND][$];

    always #5 clk = ~clk;

    seq_svm_classifier #(.W_FLAT(mk_w(0)), .B_FLAT(mk_b(0))) u0 (.clk(clk), .rst_n(rst_n), .in(din[0]), .ready(rdy[0]), .w_class(cls[0]));
    seq_svm_classifier #(.W_FLAT(mk_w(0)), .B_FLAT(mk_b(1))) u1 (.clk(clk), .rst_n(rst_n), .in(din[1]), .ready(rdy[1]), .w_class(cls[1]));
    seq_svm_classifier #(.W_FLAT(mk_w(0)), .B_FLAT(mk_b(2))) u2 (.clk(clk), .rst_n(rst_n), .in(din[2]), .ready(rdy[2]), .w_class(cls[2]));
    seq_svm_classifier #(.W_FLAT(mk_w(1)), .B_FLAT(mk_b(3))) u3 (.clk(clk), .rst_n(rst_n), .in(din[3]), .ready(rdy[3]), .w_class(cls[3]));
    seq_svm_classifier #(.W_FLAT(mk_w(2)), .B_FLAT(mk_b(4))) u4 (.clk(clk), .rst_n(rst_n), .in(din[4]), .ready(rdy[4]), .w_class(cls[4]));

    task automatic chk(string nm, int k, int act, int expv);
        ntot++;
        if (act == expv) npass++;
        else $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, k, act, expv, $time);
    endtask

    // edges since reset release
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else if (cyc < 1000) cyc <= cyc + 1;

    for (genvar k = 0; k < ND; k++) begin : g_mon
        int last_cls = 0;
        always @(negedge clk) begin
            if (rst_n) begin
                if (cyc < 18) begin
                    chk("early_ready", k, int'(rdy[k]), 0);
                end else if (cyc == 18) begin
                    chk("ready_at_18", k, int'(rdy[k]), 1);
                    if (exp_q[k].size() == 0) begin
                        chk("unexpected_result", k, int'(cls[k]), -1);
                    end else begin
                        last_cls = exp_q[k].pop_front();
                        chk("w_class", k, int'(cls[k]), last_cls);
                    end
                end else if (cyc < 1000) begin
                    chk("ready_hold", k, int'(rdy[k]), 1);
                    chk("class_hold", k, int'(cls[k]), last_cls);
                end
            end
        end
    end

    task automatic run_and_drain();
        @(negedge clk) rst_n = 1'b1;
        repeat (22) @(negedge clk);
        for (int k = 0; k < ND; k++) chk("result_missing", k, exp_q[k].size(), 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk("async_clr_ready", k, int'(rdy[k]), 0);
            chk("async_clr_class", k, int'(cls[k]), 0);
        end
    endtask

    task automatic push_exp(int e0, int e1, int e2, int e3, int e4);
        exp_q[0].push_back(e0); exp_q[1].push_back(e1); exp_q[2].push_back(e2);
        exp_q[3].push_back(e3); exp_q[4].push_back(e4);
    endtask

    initial begin
        din = '0;
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            chk("reset_ready", k, int'(rdy[k]), 0);
            chk("reset_class", k, int'(cls[k]), 0);
        end

        // bias-only winners, 255 vs -1793, signed -15 beats -85
        din[0] = 68'({$urandom(), $urandom(), $urandom()});
        din[1] = 68'({$urandom(), $urandom(), $urandom()});
        din[2] = 68'({$urandom(), $urandom(), $urandom()});
        din[3] = fill(15, 0);
        din[4] = fill(5, 0);
        push_exp(9, 0, 4, 3, 5);
        run_and_drain();

        // only feature16 lit: score3=15, score6=-1793; zero sample: score2=0 beats -100
        @(negedge clk);
        din[0] = 68'({$urandom(), $urandom(), $urandom()});
        din[1] = fill(15, 0);
        din[2] = fill(7, 0);
        din[3] = fill(15, 1);
        din[4] = fill(0, 0);
        push_exp(9, 0, 4, 3, 2);
        run_and_drain();

        // abort at edge 9 with a different sample, then start fresh
        @(negedge clk);
        din[3] = fill(15, 0);
        din[4] = fill(0, 0);
        rst_n = 1'b1;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk("abort_ready", k, int'(rdy[k]), 0);
            chk("abort_class", k, int'(cls[k]), 0);
        end
        @(negedge clk);
        din[3] = fill(0, 0);
        din[4] = fill(5, 0);
        push_exp(9, 0, 4, 6, 5);
        run_and_drain();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/seq_svm_classifier.md
Name: seq_svm_classifier

Overview:
- Sequential linear one-vs-rest SVM classifier for the 10-class Pendigits handwritten-digit task, built for printed electronics.
- Consumes one 17-feature, 4-bit-per-feature sample and serially accumulates one feature per cycle into 10 class scores.
- Adds the per-class biases, then outputs the arg-max class index with a ready flag.
- The top level of the classifier; the sample is held stable by the upstream logic.

Parameters:
- weightWidth, 8, signed weight width (two's complement).
- feature_bits, 5, width of the feature counter; must satisfy 2^feature_bits > N_features+1.
- N_features, 17, number of input features.
- biasWidth, 8, signed bias width.
- inputWidth, 4, unsigned feature width.
- W_FLAT, trained Pendigits coefficients, 10*N_features*weightWidth bits; weight (c,i) at bit offset (c*N_features+i)*weightWidth.
- B_FLAT, trained Pendigits biases, 10*biasWidth bits; bias c at bit offset c*biasWidth.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low; also the per-sample start (release = start).
- in  in  N_features*inputWidth (68)  sample; feature i = in[i*inputWidth +: inputWidth], unsigned.
- ready  out  1  high when w_class is valid.
- w_class  out  4  predicted class, 0..9.

Behaviour:
- Single clock domain; reset is asynchronous and active-low, named rst_n.
- Reset (rst_n=0, asynchronous):
  - feature counter cnt=0 and all 10 accumulators acc[c]=0.
  - ready=0 and w_class=0.
- States:
  - ACC (cnt 0..N_features-1).
  - FINAL (cnt==N_features).
  - DONE (cnt==N_features+1; holds there).
- ACC, each rising edge:
  - for all c in 0..9 in parallel: acc[c] += sext(w[c][cnt]) * zext(x[cnt]).
  - cnt++.
- FINAL edge:
  - score[c] = acc[c] + sext(b[c]), with the bias added at the LSB, no scaling.
  - w_class <= argmax score.
  - ready <= 1; cnt <= N_features+1.
- DONE: outputs and accumulators frozen; ready stays 1 until rst_n falls.
- Latency: ready rises on the (N_features+1)th rising edge after rst_n release (edge 18 by default).
- Arithmetic:
  - Products are signed, weightWidth+inputWidth+1 bits.
  - Accumulators and scores are signed, weightWidth+inputWidth+feature_bits+1 = 18 bits; no overflow is possible at the defaults, and no saturation is applied.
- Arg-max:
  - Compare with strict greater-than in class order 0..9, so a tie resolves to the lowest index.
  - Implement as a comparator chain or tree with identical tie semantics.
- Input:
  - in must be stable from rst_n release until ready.
  - Changes during ACC are undefined (a feature is sampled only in its own cycle).
- Reset mid-operation: abort immediately; clear per the reset values; the next release starts a new sample from feature 0.
- Back-to-back samples: the driver pulses rst_n low for at least half a cycle after ready; no other start signal exists.
- Weights and biases are constants; synthesis folds constant multiplies per feature via a cnt-indexed mux.

Test Plan:
1. W_FLAT all 0; B_FLAT b[c]=c; any input; release reset -> ready=0 for edges 1..17, ready=1 at edge 18, w_class=9.
2. W_FLAT all 0, B_FLAT all 0 (full tie) -> w_class=0; with b[4]=b[7]=5 and the others 0 -> w_class=4.
3. w[3][i]=1 for all i, others 0, biases 0, all features 15 -> score3=255, w_class=3. Then set w[6][16]=-128, b[6]=127, only feature16=15 -> score6=-1793, class 3 still wins.
4. w[2][i]=-1, w[5][i]=1, b[5]=-100, b[2]=0, all features 5 -> score5=-15 < score2=-85? No: score2=-85, score5=-15, w_class=5; confirms signed compare and bias add.
5. Assert rst_n at edge 9 mid-accumulation with a different sample applied -> ready and w_class clear instantly. After release, ready at edge 18 with the result of the new sample only.
6. Default coefficients, full Pendigits test file with rst_n pulsed between samples -> every w_class bit-exact to the golden fixed-point model; accuracy is reported.
